sopc_run_ctrl: RTL

Synthesizable run controller and writeback tracer for the minimal OpenMIPS SOPC. It replaces fixed-delay reset and stop sequencing with a parametrised one: a programmable reset hold, a cycle watchdog and a software end-of-test condition. It also captures register-file writebacks to a configurable set of registers into a trace FIFO. It sits between the top-level clock/reset and the core's `rst` input, and snoops the core's regfile write port.

---
 rtl/sopc_run_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sopc_run_ctrl.sv
// rtl/sopc_run_ctrl.sv - run controller (reset hold, watchdog, end-write stop) with optional writeback trace FIFO (SOPC_RUN_CTRL_TRACE_EN)
module sopc_run_ctrl #(
    parameter int          RST_HOLD   = 10,
    parameter logic [31:0] MAX_CYCLES = 32'd150,
    parameter logic [4:0]  END_REG    = 5'd31,
    parameter logic [31:0] END_VALUE  = 32'hDEAD_BEEF,
    parameter logic [31:0] WATCH_MASK = 32'h8000_001F,
    parameter int          DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       wb_we,
    input  logic [4:0]                 wb_waddr,
    input  logic [31:0]                wb_wdata,
    output logic                       cpu_rst,
    output logic                       busy,
    output logic                       done,
    output logic                       halted,
    output logic                       timeout,
    output logic [31:0]                cycle_count,
    input  logic                       tr_rd,
    output logic                       tr_valid,
    output logic [4:0]                 tr_addr,
    output logic [31:0]                tr_data,
    output logic [15:0]                tr_stamp,
    output logic [$clog2(DEPTH):0]     tr_count,
    output logic                       tr_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t     state;
    logic [7:0] hold_cnt;
    logic       start_acc;
    logic       end_write;

    // a run may only be (re)started from a quiescent state
    assign start_acc = start && (state == S_IDLE || state == S_DONE);
    assign end_write = wb_we && (wb_waddr == END_REG) && (wb_wdata == END_VALUE);

    // run sequencing: hold core in reset, then run until end-write or watchdog
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            hold_cnt    <= 8'd0;
            cycle_count <= 32'd0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cpu_rst     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_acc) begin
                        state       <= S_RESET;
                        hold_cnt    <= 8'd0;
                        cycle_count <= 32'd0;
                        halted      <= 1'b0;
                        timeout     <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                S_RESET: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (hold_cnt == 8'(RST_HOLD - 1)) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                    end
                end
                S_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    // end-write takes priority so a coincident watchdog expiry is not flagged
                    if (end_write) begin
                        state   <= S_DONE;
                        halted  <= 1'b1;
                        cpu_rst <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (cycle_count == MAX_CYCLES - 32'd1) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                        cpu_rst <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SOPC_RUN_CTRL_TRACE_EN
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [52:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          capture;
    logic          pop;
    logic          push;
    logic [52:0]   head;

    assign full    = (count == CW'(DEPTH));
    assign capture = (state == S_RUN) && wb_we && WATCH_MASK[wb_waddr];
    assign pop     = tr_rd && (count != '0);
    // a pop frees the slot in the same cycle, so a full FIFO still accepts
    assign push    = capture && (!full || pop);

    // pointer and occupancy bookkeeping; a new run starts with an empty trace
    always_ff @(posedge clk) begin
        if (!rst || start_acc) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tr_overflow <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (capture && full && !pop)
                tr_overflow <= 1'b1;
        end
    end

    // entry storage; contents are only observed through the valid-gated head mux
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {wb_waddr, wb_wdata, cycle_count[15:0]};
    end

    assign head     = mem[rd_ptr];
    assign tr_valid = (count != '0);
    assign tr_count = count;
    assign tr_addr  = tr_valid ? head[52:48] : 5'd0;
    assign tr_data  = tr_valid ? head[47:16] : 32'd0;
    assign tr_stamp = tr_valid ? head[15:0]  : 16'd0;
`else
    logic unused_tr_rd;

    assign unused_tr_rd = tr_rd;
    assign tr_valid     = 1'b0;
    assign tr_addr      = 5'd0;
    assign tr_data      = 32'd0;
    assign tr_stamp     = 16'd0;
    assign tr_count     = '0;
    assign tr_overflow  = 1'b0;
`endif

endmodule
